// File: rtl/vid_pkg.sv
// Shared types and constants for the video pixel shifter: RGB struct, bit-per-pixel
// constants and the colour palette table indexed [palette][2-bit code].
package vid_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam int NUM_PAL_MAX = 4;
  localparam int BPP_MONO    = 1;
  localparam int BPP_COLOUR  = 2;

  localparam rgb_t RGB_BLACK = 3'b000;
  localparam rgb_t RGB_WHITE = 3'b111;

  // Palette 0 is the classic black/blue/green/red set; the others are alternates.
  localparam rgb_t PAL [NUM_PAL_MAX][4] = '{
    '{3'b000, 3'b001, 3'b010, 3'b100},
    '{3'b000, 3'b011, 3'b101, 3'b110},
    '{3'b000, 3'b001, 3'b100, 3'b111},
    '{3'b000, 3'b110, 3'b011, 3'b111}
  };

endpackage

// File: rtl/vid_pixel_shifter_if.sv
// Pixel shifter bus: RAM word load, pixel timing controls, RGB and error flags.
// With VID_BORDER_EN defined an extra border_col input is carried.
interface vid_pixel_shifter_if #(
  parameter int WORD_W = 16,
  parameter int PAL_W  = 2
);
  logic              load;
  logic [WORD_W-1:0] data_in;
  logic              pix_en;
  logic              mode;
  logic [PAL_W-1:0]  pal_sel;
  logic              blank;
  logic              clr_err;
`ifdef VID_BORDER_EN
  logic [2:0]        border_col;
`endif
  logic              vR;
  logic              vG;
  logic              vB;
  logic              underrun;
  logic              overrun;

  modport master (
    output load, data_in, pix_en, mode, pal_sel, blank, clr_err,
`ifdef VID_BORDER_EN
    output border_col,
`endif
    input  vR, vG, vB, underrun, overrun
  );

  modport slave (
    input  load, data_in, pix_en, mode, pal_sel, blank, clr_err,
`ifdef VID_BORDER_EN
    input  border_col,
`endif
    output vR, vG, vB, underrun, overrun
  );
endinterface

// File: rtl/vid_palette_lut.sv
// Combinational colour decode: 2-bit code (colour) or LSB (mono) to RGB.
// Out-of-range palette selects fall back to palette 0.
module vid_palette_lut
  import vid_pkg::*;
#(
  parameter int NUM_PAL = 4,
  parameter int PAL_W   = 2
) (
  input  logic [1:0]       code,
  input  logic             mode,
  input  logic [PAL_W-1:0] pal_sel,
  output rgb_t             rgb
);

  int         sel;
  logic [1:0] pal_idx;

  always_comb begin
    sel     = int'(pal_sel);
    pal_idx = 2'd0;
    if (sel < NUM_PAL && sel < NUM_PAL_MAX) begin
      pal_idx = sel[1:0];
    end
    rgb = RGB_BLACK;
    if (!mode) begin
      rgb = code[0] ? RGB_WHITE : RGB_BLACK;
    end else begin
      rgb = PAL[pal_idx][code];
    end
  end

endmodule

// File: rtl/vid_pixel_shifter.sv
// RAM word to RGB pixel serialiser with a one-word hold buffer and sticky
// underrun/overrun flags. Define VID_BORDER_EN to drive border_col during blank.
module vid_pixel_shifter
  import vid_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int NUM_PAL  = 4,
  parameter int DATA_INV = 1
) (
  input logic                PIN_CLK,
  input logic                PIN_R,
  vid_pixel_shifter_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int PAL_W = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
  localparam logic [CNT_W-1:0] PPW_MONO_M1   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] PPW_COLOUR_M1 = CNT_W'(WORD_W / 2 - 1);

  logic [WORD_W-1:0] hold_reg, hold_next;
  logic              hold_mode_reg, hold_mode_next;
  logic              hold_valid_reg, hold_valid_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic              shift_mode_reg, shift_mode_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  rgb_t              rgb_reg, rgb_next;
  logic              underrun_reg, underrun_next;
  logic              overrun_reg, overrun_next;

  logic [WORD_W-1:0] capture_word;
  logic              step;
  logic              cnt_zero;
  logic              transfer;
  logic              underrun_set;
  logic              overrun_set;
  logic [1:0]        pix_code;
  logic              pix_mode;
  rgb_t              lut_rgb;
  rgb_t              blank_rgb;

  assign capture_word = (DATA_INV != 0) ? ~bus.data_in : bus.data_in;
  assign step         = bus.pix_en & ~bus.blank;
  assign cnt_zero     = (count_reg == '0);
  assign transfer     = step & cnt_zero & hold_valid_reg;

  // An empty shifter means the pixel comes straight from the hold word.
  assign pix_code = cnt_zero ? hold_reg[1:0] : shift_reg[1:0];
  assign pix_mode = cnt_zero ? hold_mode_reg : shift_mode_reg;

`ifdef VID_BORDER_EN
  assign blank_rgb = rgb_t'(bus.border_col);
`else
  assign blank_rgb = RGB_BLACK;
`endif

  vid_palette_lut #(
    .NUM_PAL (NUM_PAL),
    .PAL_W   (PAL_W)
  ) u_lut (
    .code    (pix_code),
    .mode    (pix_mode),
    .pal_sel (bus.pal_sel),
    .rgb     (lut_rgb)
  );

  always_comb begin
    hold_next       = hold_reg;
    hold_mode_next  = hold_mode_reg;
    hold_valid_next = hold_valid_reg;
    shift_next      = shift_reg;
    shift_mode_next = shift_mode_reg;
    count_next      = count_reg;
    rgb_next        = rgb_reg;
    underrun_set    = 1'b0;
    overrun_set     = 1'b0;

    if (bus.pix_en) begin
      if (bus.blank) begin
        rgb_next = blank_rgb;
      end else if (!cnt_zero) begin
        rgb_next   = lut_rgb;
        shift_next = shift_mode_reg ? (shift_reg >> BPP_COLOUR) : (shift_reg >> BPP_MONO);
        count_next = count_reg - CNT_W'(1);
      end else if (hold_valid_reg) begin
        rgb_next        = lut_rgb;
        shift_next      = hold_mode_reg ? (hold_reg >> BPP_COLOUR) : (hold_reg >> BPP_MONO);
        count_next      = hold_mode_reg ? PPW_COLOUR_M1 : PPW_MONO_M1;
        shift_mode_next = hold_mode_reg;
        hold_valid_next = 1'b0;
      end else begin
        rgb_next     = RGB_BLACK;
        underrun_set = 1'b1;
      end
    end

    // A load on the transfer edge refills hold after the old word moved out.
    if (bus.load) begin
      hold_next       = capture_word;
      hold_mode_next  = bus.mode;
      hold_valid_next = 1'b1;
      overrun_set     = hold_valid_reg & ~transfer;
    end

    underrun_next = (underrun_reg & ~bus.clr_err) | underrun_set;
    overrun_next  = (overrun_reg & ~bus.clr_err) | overrun_set;
  end

  always_ff @(posedge PIN_CLK) begin
    if (PIN_R) begin
      hold_reg       <= '0;
      hold_mode_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
      shift_reg      <= '0;
      shift_mode_reg <= 1'b0;
      count_reg      <= '0;
      rgb_reg        <= RGB_BLACK;
      underrun_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      hold_reg       <= hold_next;
      hold_mode_reg  <= hold_mode_next;
      hold_valid_reg <= hold_valid_next;
      shift_reg      <= shift_next;
      shift_mode_reg <= shift_mode_next;
      count_reg      <= count_next;
      rgb_reg        <= rgb_next;
      underrun_reg   <= underrun_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign bus.vR       = rgb_reg.r;
  assign bus.vG       = rgb_reg.g;
  assign bus.vB       = rgb_reg.b;
  assign bus.underrun = underrun_reg;
  assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_vid_pixel_shifter.sv
// Scoreboard bench for vid_pixel_shifter: the driver queues hand-computed
// {rgb, underrun, overrun} per cycle, the monitor checks them after each edge.
module tb_vid_pixel_shifter;

  localparam int WORD_W  = 16;
  localparam int NUM_PAL = 4;
  localparam int PAL_W   = 2;

  localparam logic [2:0] K = 3'b000;
  localparam logic [2:0] B = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] W = 3'b111;
  localparam logic [2:0] C = 3'b011;
`ifdef VID_BORDER_EN
  localparam logic [2:0] BLANK_RGB = 3'b001;
`else
  localparam logic [2:0] BLANK_RGB = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_v = 1'b1;
  logic mode_v = 1'b1;
  logic [PAL_W-1:0] pal_v = '0;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  vid_pixel_shifter_if #(.WORD_W(WORD_W), .PAL_W(PAL_W)) bus ();

  vid_pixel_shifter #(
    .WORD_W   (WORD_W),
    .NUM_PAL  (NUM_PAL),
    .DATA_INV (0)
  ) dut (
    .PIN_CLK (clk),
    .PIN_R   (rst),
    .bus     (bus)
  );

  task automatic cyc(input logic pe, input logic bl, input logic ld, input logic [15:0] d,
                     input logic cl, input logic [2:0] e_rgb, input logic e_u,
                     input logic e_o, input string nm);
    @(negedge clk);
    rst         = rst_v;
    bus.mode    = mode_v;
    bus.pal_sel = pal_v;
    bus.pix_en  = pe;
    bus.blank   = bl;
    bus.load    = ld;
    bus.data_in = d;
    bus.clr_err = cl;
    exp_q.push_back({e_rgb, e_u, e_o});
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    rst_v = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, nm);
    rst_v = 1'b0;
  endtask

  // Monitor: compares every queued expectation just after the edge it describes.
  initial begin
    logic [4:0] e;
    logic [4:0] got;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {bus.vR, bus.vG, bus.vB, bus.underrun, bus.overrun};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got rgb=%b und=%b ovr=%b, expected rgb=%b und=%b ovr=%b",
                   nm, got[4:2], got[1], got[0], e[4:2], e[1], e[0]);
        end else begin
          $display("ok   %s: rgb=%b und=%b ovr=%b", nm, got[4:2], got[1], got[0]);
        end
      end
    end
  end

  initial begin
    logic [2:0] seq_a [8];
    seq_a = '{R, G, B, K, R, G, B, K};

    bus.load = 1'b0; bus.data_in = '0; bus.pix_en = 1'b0; bus.mode = 1'b1;
    bus.pal_sel = '0; bus.blank = 1'b0; bus.clr_err = 1'b0;
`ifdef VID_BORDER_EN
    bus.border_col = 3'b001;
`endif

    // Reset state, including pix_en asserted while in reset.
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, "reset_idle");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, "reset_pix");
    rst_v = 1'b0;

    // Colour 0x1B1B: red, green, blue, black twice, then underrun.
    mode_v = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 16'h1B1B, 1'b0, K, 1'b0, 1'b0, "A_load");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, seq_a[i], 1'b0, 1'b0, $sformatf("A_p%0d", i));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b1, 1'b0, "A_underrun");
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, K, 1'b0, 1'b0, "A_clr_err");

    // Mono 0x0001 then 0x0003 loaded mid-word: continuous, no underrun.
    mode_v = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, K, 1'b0, 1'b0, "B_load");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, W, 1'b0, 1'b0, "B_p0");
    for (int i = 1; i < 16; i++)
      cyc(1'b1, 1'b0, (i == 9), 16'h0003, 1'b0, K, 1'b0, 1'b0, $sformatf("B_p%0d", i));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, W, 1'b0, 1'b0, "B_w2_p0");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, W, 1'b0, 1'b0, "B_w2_p1");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, "B_w2_p2");
    do_reset("B_reset");

    // Two loads without pixels: overrun, second word shown, clr_err clears.
    mode_v = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, K, 1'b0, 1'b0, "C_load1");
    cyc(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, K, 1'b0, 1'b1, "C_load2_overrun");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, G, 1'b0, 1'b1, "C_word2_p0");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, K, 1'b0, 1'b0, "C_clr_err");
    do_reset("C_reset");

    // Load on the transfer edge: both words in order, no overrun.
    cyc(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, K, 1'b0, 1'b0, "D_load1");
    cyc(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, R, 1'b0, 1'b0, "D_xfer_and_load");
    for (int i = 1; i < 8; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, $sformatf("D_w1_p%0d", i));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, B, 1'b0, 1'b0, "D_w2_p0");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, "D_w2_p1");
    do_reset("D_reset");

    // Blank mid-word freezes the shifter; pix_en=0 holds; pal_sel acts at once.
    cyc(1'b0, 1'b0, 1'b1, 16'h1B1B, 1'b0, K, 1'b0, 1'b0, "E_load");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, R, 1'b0, 1'b0, "E_p0");
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, G, 1'b0, 1'b0, "E_p1");
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, G, 1'b0, 1'b0, "E_pix_en_low");
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, BLANK_RGB, 1'b0, 1'b0, $sformatf("E_blank%0d", i));
    pal_v = 2'd1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, C, 1'b0, 1'b0, "E_p2_pal1");
    pal_v = 2'd0;
    for (int i = 3; i < 8; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, seq_a[i], 1'b0, 1'b0, $sformatf("E_p%0d", i));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b1, 1'b0, "E_underrun");
    do_reset("E_reset");

    // Reset mid-word drops shifter, hold and flags.
    cyc(1'b0, 1'b0, 1'b1, 16'h1B1B, 1'b0, K, 1'b0, 1'b0, "F_load1");
    cyc(1'b0, 1'b0, 1'b1, 16'h1B1B, 1'b0, K, 1'b0, 1'b1, "F_load2_overrun");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, seq_a[i], 1'b0, 1'b1, $sformatf("F_p%0d", i));
    rst_v = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b0, 1'b0, "F_reset_midword");
    rst_v = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, K, 1'b1, 1'b0, "F_underrun_after_reset");

    @(negedge clk);
    bus.pix_en = 1'b0;
    bus.load   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
